dff_reg_arbiter: RTL and testbench
==================================

DFF_REG_ARBITER -- requirements
Module: dff_reg_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, bit width of the shared storage register and of each requester data lane.
REQ-002 Parameter: NREQ, 4, number of requesters; fixed at 4 in this revision.
REQ-003 Port: CLK  input  1  single clock, rising-edge active.
REQ-004 Port: RSTB  input  1  reset, asynchronous, active-low.
REQ-005 Port: REQ  input  NREQ  level request per requester; held high until ACK or voluntary drop.
REQ-006 Port: DIN  input  NREQ*WIDTH  packed write data; lane i = DIN[i*WIDTH +: WIDTH].
REQ-007 Port: GNT  output  NREQ  one-hot grant, all-zero when no owner.
REQ-008 Port: ACK  output  NREQ  one-hot, one-cycle write-complete pulse to the owner.
REQ-009 Port: Q  output  WIDTH  shared register contents.
REQ-010 Port: QB  output  WIDTH  bitwise complement of Q at all times.
REQ-011 Port: OWNER  output  2  index of the current/last granted requester.
REQ-012 Port: BUSY  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL be a four-state FSM: IDLE, GRANT, WRITE, DONE.
REQ-014 IDLE: if REQ != 0 at a rising edge, the block SHALL select a winner round-robin, searching from index PTR upward with wrap 3->0, and enter GRANT with GNT[winner]=1 and OWNER=winner.
REQ-015 IDLE with REQ == 0: the block SHALL remain in IDLE with GNT=0, ACK=0 and BUSY=0.
REQ-016 GRANT: if REQ[OWNER]=1, the block SHALL capture DIN lane OWNER into a hold register and enter WRITE.
REQ-017 GRANT with REQ[OWNER]=0 (abort): the block SHALL clear GNT, return to IDLE, issue no ACK, leave Q unchanged and leave PTR unchanged.
REQ-018 WRITE: the block SHALL load Q from the hold register, assert ACK[OWNER], and enter DONE; changes on DIN after the GRANT edge SHALL NOT affect Q.
REQ-019 DONE: the block SHALL clear ACK and GNT, set PTR=(OWNER+1) mod 4, and return to IDLE.
REQ-020 Latency: with the request sampled at edge n, Q and ACK SHALL update at edge n+2, ACK SHALL fall at edge n+3, and the next grant SHALL be possible at edge n+4.
REQ-021 Requests that rise or fall in GRANT, WRITE or DONE for non-owners SHALL be ignored until the next IDLE evaluation.
REQ-022 A sole active requester SHALL be granted on consecutive transactions; the round-robin search SHALL wrap back to it.
REQ-023 Q SHALL change only in the WRITE state, and QB SHALL equal ~Q in every cycle.

Reset
REQ-024 RSTB=0 SHALL immediately force: state=IDLE, Q=0, QB=all ones, hold=0, GNT=0, ACK=0, OWNER=0, PTR=0, BUSY=0.
REQ-025 Reset asserted mid-transaction SHALL abort it with no partial write; the first arbitration SHALL occur at the first rising edge with RSTB=1.

Structure
REQ-026 A shared package SHALL hold the state encodings (2-bit), the NREQ constant and the WIDTH default.
REQ-027 The round-robin winner selection SHALL be a combinational sub-module, rr_pick, with inputs REQ and PTR and outputs a winner index and valid.
REQ-028 The FSM, hold register, Q register and PTR SHALL reside in dff_reg_arbiter.

Verification
REQ-029 Reset: RSTB=0 asserted during WRITE -> Q=8'h00, QB=8'hFF, GNT=0, ACK=0 with no clock edge, and Q is not updated afterward.
REQ-030 Single requester: REQ=4'b0010, DIN lane1=8'hA5 -> GNT=0010 after edge0, Q=8'hA5 and ACK=0010 after edge2, IDLE and BUSY=0 after edge3.
REQ-031 Fairness: REQ=4'b1111 held, lanes 8'h11/22/33/44, PTR=0 -> grant order 0,1,2,3,0 with Q=11,22,33,44,11, one transaction per 4 cycles.
REQ-032 Abort: REQ[2] dropped during GRANT -> no ACK, Q unchanged, IDLE next, and next winner searched from the old PTR.
REQ-033 Late request: REQ[3] raised during WRITE of owner 0 -> not granted until DONE, then granted at the next IDLE edge.
REQ-034 Data hold: DIN lane0 changed 8'h5A->8'hFF on the WRITE edge after GRANT captured 8'h5A -> Q=8'h5A.

Source files
------------

// File: rtl/dff_reg_arbiter_pkg.sv
// Shared definitions for the dff_reg_arbiter slice.
//   - state_t   : 2-bit FSM encoding (IDLE, GRANT, WRITE, DONE)
//   - NREQ_C    : number of requesters (fixed at 4)
//   - WIDTH_DEF : default data width of the shared register
//   - IDX_W     : width of a requester index
//   - onehot()  : index -> one-hot requester vector
package dff_reg_arbiter_pkg;

  localparam int NREQ_C    = 4;
  localparam int WIDTH_DEF = 8;
  localparam int IDX_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [NREQ_C-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ_C-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dff_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner selection.
// Ports:
//   req    : request vector, one bit per requester
//   ptr    : index the search starts from (wraps 3 -> 0)
//   winner : first requesting index at or after ptr
//   valid  : high when any request is active
module rr_pick
  import dff_reg_arbiter_pkg::*;
(
  input  logic [NREQ_C-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  winner,
  output logic              valid
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down to offset 0 so the nearest
  // requester after ptr is the last (and therefore winning) assignment.
  // The 2-bit index addition wraps naturally.
  always_comb begin
    winner = ptr;
    valid  = 1'b0;
    idx    = '0;
    for (int k = NREQ_C - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: round-robin arbitrated write access to one shared register.
// Ports:
//   CLK   : clock, rising edge
//   RSTB  : asynchronous active-low reset
//   REQ   : level request per requester
//   DIN   : packed write data, lane i = DIN[i*WIDTH +: WIDTH]
//   GNT   : one-hot grant, zero when no owner
//   ACK   : one-cycle one-hot write-complete pulse
//   Q/QB  : shared register and its complement
//   OWNER : current / last granted requester
//   BUSY  : high whenever a transaction is in flight
// A transaction sampled at edge n grants at n, captures DIN at n+1,
// writes Q and raises ACK at n+2, and returns to IDLE at n+3.
module dff_reg_arbiter
  import dff_reg_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_C
) (
  input  logic                  CLK,
  input  logic                  RSTB,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] DIN,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       ACK,
  output logic [WIDTH-1:0]      Q,
  output logic [WIDTH-1:0]      QB,
  output logic [IDX_W-1:0]      OWNER,
  output logic                  BUSY
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] owner_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic [WIDTH-1:0] hold_r;
  logic [WIDTH-1:0] q_r;

  rr_pick u_rr_pick (
    .req    (REQ),
    .ptr    (ptr_r),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_vld) state_nxt = ST_GRANT;
      // Owner dropping its request before capture aborts with no write.
      ST_GRANT: state_nxt = REQ[owner_r] ? ST_WRITE : ST_IDLE;
      ST_WRITE: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      owner_r <= '0;
      ptr_r   <= '0;
      hold_r  <= '0;
      q_r     <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (pick_vld) owner_r <= pick_idx;
        // Capture here so DIN changes after this edge cannot reach Q.
        ST_GRANT: if (REQ[owner_r]) hold_r <= DIN[int'(owner_r)*WIDTH +: WIDTH];
        ST_WRITE: q_r <= hold_r;
        ST_DONE:  ptr_r <= owner_r + IDX_W'(1);
      endcase
    end
  end

  // Outputs decode directly from reset-cleared registers, so reset
  // takes effect on them without waiting for a clock edge.
  assign GNT   = (state != ST_IDLE) ? onehot(owner_r) : '0;
  assign ACK   = (state == ST_DONE) ? onehot(owner_r) : '0;
  assign BUSY  = (state != ST_IDLE);
  assign OWNER = owner_r;
  assign Q     = q_r;
  assign QB    = ~q_r;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
module tb_dff_reg_arbiter;

  logic        clk;
  logic        rstb;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic [7:0]  qb;
  logic [1:0]  owner;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  dff_reg_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .CLK   (clk),
    .RSTB  (rstb),
    .REQ   (req),
    .DIN   (din),
    .GNT   (gnt),
    .ACK   (ack),
    .Q     (q),
    .QB    (qb),
    .OWNER (owner),
    .BUSY  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: m_age counts edges since the grant
  // (-1 = no transaction in flight).
  int         m_age   = -1;
  logic [1:0] m_owner = 2'd0;
  logic [1:0] m_ptr   = 2'd0;
  logic [7:0] m_hold  = 8'h00;
  logic [7:0] m_q     = 8'h00;

  always @(posedge clk or negedge rstb) begin : model
    int w;
    if (!rstb) begin
      m_age   <= -1;
      m_owner <= 2'd0;
      m_ptr   <= 2'd0;
      m_hold  <= 8'h00;
      m_q     <= 8'h00;
    end else begin
      case (m_age)
        -1: begin
          w = -1;
          for (int i = 3; i >= 0; i--)
            if (req[(int'(m_ptr) + i) % 4]) w = (int'(m_ptr) + i) % 4;
          if (w >= 0) begin
            m_owner <= 2'(w);
            m_age   <= 0;
          end
        end
        0: begin
          if (req[m_owner]) begin
            m_hold <= din[int'(m_owner)*8 +: 8];
            m_age  <= 1;
          end else begin
            m_age <= -1;
          end
        end
        1: begin
          m_q   <= m_hold;
          m_age <= 2;
        end
        default: begin
          m_ptr <= m_owner + 2'd1;
          m_age <= -1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_gnt",   {28'd0, gnt},   (m_age >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("cyc_ack",   {28'd0, ack},   (m_age == 2) ? (32'd1 << m_owner) : 32'd0);
      chk("cyc_busy",  {31'd0, busy},  {31'd0, (m_age >= 0)});
      chk("cyc_owner", {30'd0, owner}, {30'd0, m_owner});
      chk("cyc_q",     {24'd0, q},     {24'd0, m_q});
      chk("cyc_qb",    {24'd0, qb},    {24'd0, ~m_q});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    #1;
    chk("rst_q",    {24'd0, q},     32'h00);
    chk("rst_qb",   {24'd0, qb},    32'hFF);
    chk("rst_gnt",  {28'd0, gnt},   32'h0);
    chk("rst_ack",  {28'd0, ack},   32'h0);
    chk("rst_own",  {30'd0, owner}, 32'h0);
    chk("rst_busy", {31'd0, busy},  32'h0);
    tick();
    rstb = 1'b1;
  endtask

  logic [7:0] lane_exp [4];

  initial begin
    rstb = 1'b1;
    req  = 4'b0000;
    din  = 32'h0;
    #1;
    do_reset();
    chk_on = 1'b1;

    // Single requester on lane 1
    req = 4'b0010;
    din = 32'h0000A500;
    tick();
    chk("single_gnt", {28'd0, gnt}, 32'h2);
    chk("single_own", {30'd0, owner}, 32'h1);
    tick();
    tick();
    chk("single_q",   {24'd0, q},   32'hA5);
    chk("single_ack", {28'd0, ack}, 32'h2);
    chk("model_q_pin", {24'd0, m_q}, 32'hA5);
    req = 4'b0000;
    tick();
    chk("single_busy", {31'd0, busy}, 32'h0);
    chk("single_ack0", {28'd0, ack},  32'h0);

    // Fairness: all four requesting from PTR=0
    do_reset();
    req = 4'b1111;
    din = 32'h44332211;
    lane_exp[0] = 8'h11; lane_exp[1] = 8'h22; lane_exp[2] = 8'h33; lane_exp[3] = 8'h44;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("fair_own", {30'd0, owner}, t % 4);
      chk("fair_gnt", {28'd0, gnt},   32'd1 << (t % 4));
      tick();
      tick();
      chk("fair_q",   {24'd0, q},     {24'd0, lane_exp[t % 4]});
      chk("fair_ack", {28'd0, ack},   32'd1 << (t % 4));
      tick();
    end
    req = 4'b0000;

    // Abort: requester 2 drops during GRANT, PTR must stay 0
    do_reset();
    req = 4'b0100;
    din = 32'h00AB0000;
    tick();
    chk("abort_gnt", {28'd0, gnt}, 32'h4);
    req = 4'b0000;
    tick();
    chk("abort_gnt0", {28'd0, gnt},  32'h0);
    chk("abort_busy", {31'd0, busy}, 32'h0);
    chk("abort_ack",  {28'd0, ack},  32'h0);
    chk("abort_q",    {24'd0, q},    32'h00);
    req = 4'b1001;
    tick();
    chk("abort_next_own", {30'd0, owner}, 32'h0);
    chk("model_own_pin",  {30'd0, m_owner}, 32'h0);
    tick();
    tick();
    req = 4'b0000;
    tick();

    // Late request from 3 during WRITE of owner 0
    do_reset();
    req = 4'b0001;
    din = 32'h00000077;
    tick();
    tick();
    req = 4'b1001;
    tick();
    chk("late_gnt_own0", {28'd0, gnt}, 32'h1);
    chk("late_ack",      {28'd0, ack}, 32'h1);
    chk("late_q",        {24'd0, q},   32'h77);
    req = 4'b1000;
    tick();
    chk("late_idle_gnt",  {28'd0, gnt},  32'h0);
    chk("late_idle_busy", {31'd0, busy}, 32'h0);
    tick();
    chk("late_gnt3", {28'd0, gnt},   32'h8);
    chk("late_own3", {30'd0, owner}, 32'h3);
    tick();
    tick();
    req = 4'b0000;
    tick();

    // Data hold: DIN changes after capture
    do_reset();
    req = 4'b0001;
    din = 32'h0000005A;
    tick();
    tick();
    din = 32'h000000FF;
    tick();
    chk("hold_q", {24'd0, q}, 32'h5A);
    req = 4'b0000;
    tick();

    // Asynchronous reset during WRITE
    req = 4'b0010;
    din = 32'h0000C300;
    tick();
    tick();
    #2;
    rstb = 1'b0;
    #1;
    chk("arst_q",    {24'd0, q},    32'h00);
    chk("arst_qb",   {24'd0, qb},   32'hFF);
    chk("arst_gnt",  {28'd0, gnt},  32'h0);
    chk("arst_ack",  {28'd0, ack},  32'h0);
    chk("arst_busy", {31'd0, busy}, 32'h0);
    tick();
    chk("arst_q_held", {24'd0, q}, 32'h00);
    rstb = 1'b1;
    tick();
    chk("arst_first_gnt", {28'd0, gnt}, 32'h2);
    tick();
    tick();
    chk("arst_q_after", {24'd0, q}, 32'hC3);
    req = 4'b0000;
    tick();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      int r;
      r   = int'($urandom_range(0, 99));
      din = $urandom;
      rstb = (r < 2) ? 1'b0 : 1'b1;
      if (r >= 2 && r < 30) req = 4'($urandom);
      tick();
    end
    rstb = 1'b1;
    req  = 4'b0000;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
